// File: rtl/lif_mon_pkg.sv
// Shared types and helpers for the spike-rate monitor.
//   CNT_W / CNT_MAX : per-neuron count width and its saturation ceiling
//   state_e         : monitor FSM states
//   cnt_res_t       : {ovf, cnt} result of one saturating increment
//   sat_inc()       : saturating +0/+1, reports an increment lost to saturation
package lif_mon_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

  typedef struct packed {
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } cnt_res_t;

  function automatic cnt_res_t sat_inc(input logic [CNT_W-1:0] cnt, input logic b);
    cnt_res_t r;
    r.ovf = b && (cnt == CNT_MAX);
    r.cnt = r.ovf ? cnt : cnt + {{(CNT_W-1){1'b0}}, b};
    return r;
  endfunction

endpackage

// File: rtl/spike_counter_sat.sv
// Saturating spike counter for one neuron.
//   clk, rst_n : clock, async active-low reset
//   en         : count this cycle's spike
//   clr        : restart the count; a spike in the same cycle becomes the new count
//   spike      : spike bit
//   cnt        : current count (saturates at CNT_MAX)
//   ovf        : sticky flag, set when an increment was lost to saturation
module spike_counter_sat
  import lif_mon_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             spike,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  cnt_res_t         res;

  assign res = sat_inc(cnt_q, spike);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (clr) begin
      cnt_q <= {{(CNT_W-1){1'b0}}, spike};
      ovf_q <= 1'b0;
    end else if (en) begin
      cnt_q <= res.cnt;
      ovf_q <= ovf_q | res.ovf;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/spike_rate_monitor.sv
// Spike-rate monitor: counts per-neuron spikes over a window of enabled
// cycles, snapshots the counts at window end and presents one neuron's
// snapshot at a time through a registered mux.
//   clk, rst_n  : clock, async active-low reset
//   ena         : low freezes timer and counters, spikes ignored
//   spikes_in   : 1-cycle spike pulses, one bit per neuron
//   win_len     : window length in enabled cycles, 0 = idle
//   sel         : neuron shown on count_out / ovf_out
//   count_out   : registered snapshot count of neuron sel
//   ovf_out     : registered snapshot overflow flag of neuron sel
//   frame_valid : 1-cycle pulse when a new snapshot is available
//   frame_id    : snapshot sequence number, wraps 15->0
// Count width comes from lif_mon_pkg::CNT_W.
module spike_rate_monitor
  import lif_mon_pkg::*;
#(
  parameter  int N_NEUR = 4,
  parameter  int WIN_W  = 16,
  localparam int SEL_W  = (N_NEUR > 1) ? $clog2(N_NEUR) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [N_NEUR-1:0] spikes_in,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [SEL_W-1:0]  sel,
  output logic [CNT_W-1:0]  count_out,
  output logic              ovf_out,
  output logic              frame_valid,
  output logic [3:0]        frame_id
);

  state_e                         state_q, state_d;
  logic [WIN_W-1:0]               timer_q, timer_d;
  logic                           cnt_en, last, clr;
  logic [N_NEUR-1:0]              cnt_spk;
  logic [N_NEUR-1:0][CNT_W-1:0]   cnt;
  logic [N_NEUR-1:0]              ovf;
  cnt_res_t [N_NEUR-1:0]          fin;
  logic [N_NEUR-1:0][CNT_W-1:0]   snap_cnt_q, snap_cnt_d;
  logic [N_NEUR-1:0]              snap_ovf_q, snap_ovf_d;
  logic [3:0]                     frame_id_q;
  logic                           fv_q;
  logic [CNT_W-1:0]               count_q, mux_cnt;
  logic                           ovf_out_q, mux_ovf;

  assign cnt_en = ena && (state_q == COUNT);
  assign last   = cnt_en && (timer_q == '0);
  // Counters restart at window end and stay pinned at 0 while idle. The
  // last-cycle spike goes into the snapshot, not into the next window.
  assign clr     = last || (state_q == IDLE);
  assign cnt_spk = spikes_in & {N_NEUR{cnt_en && !last}};

  for (genvar g = 0; g < N_NEUR; g++) begin : g_neur
    spike_counter_sat u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cnt_en),
      .clr   (clr),
      .spike (cnt_spk[g]),
      .cnt   (cnt[g]),
      .ovf   (ovf[g])
    );
    // Final value includes the spike seen in the last window cycle.
    assign fin[g]        = sat_inc(cnt[g], spikes_in[g]);
    assign snap_cnt_d[g] = last ? fin[g].cnt : snap_cnt_q[g];
    assign snap_ovf_d[g] = last ? (ovf[g] | fin[g].ovf) : snap_ovf_q[g];
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (ena && (win_len != '0)) begin
          timer_d = win_len - WIN_W'(1);
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (ena) begin
          if (timer_q != '0) begin
            timer_d = timer_q - WIN_W'(1);
          end else if (win_len != '0) begin
            timer_d = win_len - WIN_W'(1);
          end else begin
            timer_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Mux reads the next-state snapshot so a fresh frame is on count_out in
  // the same cycle frame_valid pulses.
  always_comb begin
    mux_cnt = '0;
    mux_ovf = 1'b0;
    for (int i = 0; i < N_NEUR; i++) begin
      if (sel == SEL_W'(i)) begin
        mux_cnt = snap_cnt_d[i];
        mux_ovf = snap_ovf_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      snap_cnt_q <= '0;
      snap_ovf_q <= '0;
      frame_id_q <= '0;
      fv_q       <= 1'b0;
      count_q    <= '0;
      ovf_out_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      snap_cnt_q <= snap_cnt_d;
      snap_ovf_q <= snap_ovf_d;
      frame_id_q <= frame_id_q + {3'b000, last};
      fv_q       <= last;
      count_q    <= mux_cnt;
      ovf_out_q  <= mux_ovf;
    end
  end

  assign count_out   = count_q;
  assign ovf_out     = ovf_out_q;
  assign frame_valid = fv_q;
  assign frame_id    = frame_id_q;

endmodule

// File: tb/tb_spike_rate_monitor.sv
module tb_spike_rate_monitor;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  spikes_in = '0;
  logic [15:0] win_len = '0;
  logic [1:0]  sel = '0;
  logic [7:0]  count_out;
  logic        ovf_out;
  logic        frame_valid;
  logic [3:0]  frame_id;

  spike_rate_monitor #(.N_NEUR(N), .WIN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spikes_in(spikes_in),
    .win_len(win_len), .sel(sel), .count_out(count_out), .ovf_out(ovf_out),
    .frame_valid(frame_valid), .frame_id(frame_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: window as "cycles remaining", counts as unbounded ints.
  bit m_active;
  int m_rem;
  int m_cnt[N];
  int m_snap[N];
  int m_fid;
  bit m_fv;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_active = 0; m_rem = 0; m_fid = 0; m_fv = 0;
    for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_snap[i] = 0; end
  endtask

  function automatic int exp_cnt(input int s);
    if (s >= N) return 0;
    return (m_snap[s] > 255) ? 255 : m_snap[s];
  endfunction

  function automatic int exp_ovf(input int s);
    if (s >= N) return 0;
    return (m_snap[s] > 255) ? 1 : 0;
  endfunction

  task automatic step(input bit e, input logic [3:0] sp, input int wl, input int s);
    ena = e; spikes_in = sp; win_len = 16'(wl); sel = 2'(s);
    m_fv = 0;
    if (!m_active) begin
      if (e && wl != 0) begin m_active = 1; m_rem = wl; end
    end else if (e) begin
      for (int i = 0; i < N; i++) m_cnt[i] += int'(sp[i]);
      m_rem--;
      if (m_rem == 0) begin
        for (int i = 0; i < N; i++) begin m_snap[i] = m_cnt[i]; m_cnt[i] = 0; end
        m_fid = (m_fid + 1) % 16;
        m_fv = 1;
        if (wl != 0) m_rem = wl; else m_active = 0;
      end
    end
    @(posedge clk); #1;
    chk("count_out", int'(count_out), exp_cnt(s));
    chk("ovf_out", int'(ovf_out), exp_ovf(s));
    chk("frame_valid", int'(frame_valid), int'(m_fv));
    chk("frame_id", int'(frame_id), m_fid);
  endtask

  task automatic do_reset(input int cyc);
    rst_n = 1'b0;
    model_clear();
    for (int k = 0; k < cyc; k++) begin
      spikes_in = 4'($urandom); ena = 1'b1; win_len = 16'd5;
      @(posedge clk); #1;
      chk("rst_count", int'(count_out), 0);
      chk("rst_ovf", int'(ovf_out), 0);
      chk("rst_fv", int'(frame_valid), 0);
      chk("rst_fid", int'(frame_id), 0);
    end
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && m_active; k++) step(1, 4'b0, 0, 0);
  endtask

  typedef struct {
    bit         e;
    logic [3:0] sp;
    int         wl;
    int         s;
    int         ec;
    int         eo;
    int         efv;
    int         efid;
  } vec_t;

  vec_t tbl[8];
  int   nf;
  int   wl_r;

  initial begin
    tbl[0] = '{1, 4'b0001, 2, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 4'b0011, 2, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 4'b0001, 0, 0, 2, 0, 1, 1};
    tbl[3] = '{1, 4'b1111, 0, 1, 1, 0, 0, 1};
    tbl[4] = '{0, 4'b0000, 3, 0, 2, 0, 0, 1};
    tbl[5] = '{1, 4'b0100, 1, 2, 0, 0, 0, 1};
    tbl[6] = '{1, 4'b0100, 1, 2, 1, 0, 1, 2};
    tbl[7] = '{1, 4'b0000, 0, 2, 0, 0, 1, 3};

    // 1: reset with spikes driven, then idle window
    do_reset(4);
    for (int k = 0; k < 50; k++) step(1, 4'($urandom), 0, k % 4);

    // directed vectors
    for (int k = 0; k < 8; k++) begin
      step(tbl[k].e, tbl[k].sp, tbl[k].wl, tbl[k].s);
      chk($sformatf("tbl%0d_cnt", k), int'(count_out), tbl[k].ec);
      chk($sformatf("tbl%0d_ovf", k), int'(ovf_out), tbl[k].eo);
      chk($sformatf("tbl%0d_fv", k), int'(frame_valid), tbl[k].efv);
      chk($sformatf("tbl%0d_fid", k), int'(frame_id), tbl[k].efid);
    end
    drain();

    // 2: 10-cycle windows, n0 every cycle, n1 every 2nd cycle
    nf = 0;
    for (int k = 0; k < 31; k++) begin
      step(1, {2'b00, (k % 2 == 0), 1'b1}, 10, k % 2);
      if (frame_valid) nf++;
    end
    chk("s2_frames", nf, 3);
    step(1, 4'b0, 0, 1);
    chk("s2_n1_count", int'(count_out), 5);
    drain();

    // 3: saturation on neuron 2, then a fresh window
    for (int k = 0; k < 301; k++) step(1, 4'b0100, (k == 300) ? 5 : 300, 2);
    chk("s3_sat_cnt", int'(count_out), 255);
    chk("s3_sat_ovf", int'(ovf_out), 1);
    for (int k = 0; k < 5; k++) step(1, 4'b0100, 0, 2);
    chk("s3_fresh_cnt", int'(count_out), 5);
    chk("s3_fresh_ovf", int'(ovf_out), 0);
    drain();

    // 4: enable freeze mid-window
    step(1, 4'b0001, 10, 0);
    for (int k = 0; k < 3; k++) step(1, 4'b0001, 10, 0);
    for (int k = 0; k < 7; k++) step(0, (k % 2) ? 4'b1111 : 4'b0000, 10, 0);
    for (int k = 0; k < 7; k++) step(1, 4'b0001, 0, 0);
    chk("s4_fv", int'(frame_valid), 1);
    chk("s4_cnt", int'(count_out), 10);
    drain();

    // 5: last-cycle spike, mid-window win_len change, win_len=1 wrap
    step(1, 4'b0, 10, 0);
    for (int k = 0; k < 9; k++) step(1, 4'b0, (k >= 4) ? 4 : 10, 0);
    step(1, 4'b0001, 4, 0);
    chk("s5_last_spike", int'(count_out), 1);
    for (int k = 0; k < 4; k++) step(1, 4'b0010, 4, 1);
    chk("s5_short_fv", int'(frame_valid), 1);
    chk("s5_short_cnt", int'(count_out), 4);
    for (int k = 0; k < 20; k++) step(1, 4'($urandom), 1, k % 4);
    drain();

    // 6: reset mid-window
    step(1, 4'b1111, 10, 0);
    for (int k = 0; k < 5; k++) step(1, 4'b1111, 10, 0);
    do_reset(3);
    step(1, 4'b0001, 10, 0);
    for (int k = 0; k < 10; k++) step(1, 4'b0001, 0, 0);
    chk("s6_fv", int'(frame_valid), 1);
    chk("s6_cnt", int'(count_out), 10);
    chk("s6_fid", int'(frame_id), 1);

    // randomized traffic against the model
    wl_r = 3;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 19) == 0) wl_r = $urandom_range(0, 12);
      if ($urandom_range(0, 399) == 0) do_reset(2);
      else step($urandom_range(0, 9) != 0, 4'($urandom), wl_r, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
